// File: rtl/esp_at_cmd.sv
// AT-command initiator: streams one of four fixed AT commands into the UART TX channel,
// then watches the RX channel for the final OK / ERROR line or a response timeout.
module esp_at_cmd #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] cmd_sel_i,
    input  logic       cmd_start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       resp_ok_o,
    output logic       resp_err_o,
    output logic       resp_timeout_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o
);
    // state     | meaning
    // IDLE      | waiting for cmd_start
    // SEND      | streaming command bytes, matchers already listening
    // WAIT_RESP | waiting for OK / ERROR line or timeout
    // DONE      | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  ok_idx_q, ok_idx_d, ok_idx_n;
    logic [2:0]  err_idx_q, err_idx_d, err_idx_n;
    logic        ok_hit_q, ok_hit_d, err_hit_q, err_hit_d;
    logic [31:0] cnt_q, cnt_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        ok_q, ok_d, err_q, err_d, to_q, to_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rx_ready_q;
    logic        rx_fire, tx_fire, ok_cmp, err_cmp;

    // Commands are left-aligned in a 13-byte window so one shift picks any byte.
    function automatic logic [7:0] rom_byte(input logic [1:0] c, input logic [3:0] i);
        logic [103:0] s;
        case (c)
            2'd0:    s = {"AT", 8'h0D, 8'h0A, 72'h0};
            2'd1:    s = {"ATE0", 8'h0D, 8'h0A, 56'h0};
            2'd2:    s = {"AT+RST", 8'h0D, 8'h0A, 40'h0};
            default: s = {"AT+CWMODE=1", 8'h0D, 8'h0A};
        endcase
        s = s << (8 * i);
        return s[103:96];
    endfunction

    function automatic logic [3:0] cmd_len(input logic [1:0] c);
        case (c)
            2'd0:    return 4'd4;
            2'd1:    return 4'd6;
            2'd2:    return 4'd8;
            default: return 4'd13;
        endcase
    endfunction

    function automatic logic [7:0] ok_char(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h4F;
            2'd1:    return 8'h4B;
            2'd2:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    function automatic logic [7:0] err_char(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h45;
            3'd1:    return 8'h52;
            3'd2:    return 8'h52;
            3'd3:    return 8'h4F;
            3'd4:    return 8'h52;
            3'd5:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    assign rx_fire = rx_valid_i && rx_ready_q;
    assign tx_fire = tx_valid_q && tx_ready_i;

    always_comb begin
        ok_idx_n  = ok_idx_q;
        err_idx_n = err_idx_q;
        ok_cmp    = 1'b0;
        err_cmp   = 1'b0;
        if (rx_fire) begin
            if (rx_data_i == ok_char(ok_idx_q)) begin
                if (ok_idx_q == 2'd3) begin
                    ok_cmp   = 1'b1;
                    ok_idx_n = 2'd0;
                end else begin
                    ok_idx_n = ok_idx_q + 2'd1;
                end
            end else begin
                ok_idx_n = (rx_data_i == 8'h4F) ? 2'd1 : 2'd0;
            end
            if (rx_data_i == err_char(err_idx_q)) begin
                if (err_idx_q == 3'd6) begin
                    err_cmp   = 1'b1;
                    err_idx_n = 3'd0;
                end else begin
                    err_idx_n = err_idx_q + 3'd1;
                end
            end else begin
                err_idx_n = (rx_data_i == 8'h45) ? 3'd1 : 3'd0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        idx_d      = idx_q;
        ok_idx_d   = ok_idx_q;
        err_idx_d  = err_idx_q;
        ok_hit_d   = ok_hit_q;
        err_hit_d  = err_hit_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        err_d      = err_q;
        to_d       = to_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            IDLE: begin
                if (cmd_start_i) begin
                    state_d    = SEND;
                    cmd_d      = cmd_sel_i;
                    idx_d      = 4'd0;
                    ok_idx_d   = 2'd0;
                    err_idx_d  = 3'd0;
                    ok_hit_d   = 1'b0;
                    err_hit_d  = 1'b0;
                    ok_d       = 1'b0;
                    err_d      = 1'b0;
                    to_d       = 1'b0;
                    busy_d     = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = rom_byte(cmd_sel_i, 4'd0);
                end
            end
            SEND: begin
                ok_idx_d  = ok_idx_n;
                err_idx_d = err_idx_n;
                ok_hit_d  = ok_hit_q | ok_cmp;
                err_hit_d = err_hit_q | err_cmp;
                if (tx_fire) begin
                    if (idx_q == cmd_len(cmd_q) - 4'd1) begin
                        state_d    = WAIT_RESP;
                        tx_valid_d = 1'b0;
                        cnt_d      = 32'd0;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        tx_data_d = rom_byte(cmd_q, idx_q + 4'd1);
                    end
                end
            end
            WAIT_RESP: begin
                ok_idx_d  = ok_idx_n;
                err_idx_d = err_idx_n;
                cnt_d     = cnt_q + 32'd1;
                // A match completing on the timeout cycle takes priority.
                if (ok_cmp || ok_hit_q || err_cmp || err_hit_q
                        || cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (ok_cmp || ok_hit_q)        ok_d  = 1'b1;
                    else if (err_cmp || err_hit_q) err_d = 1'b1;
                    else                           to_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cmd_q      <= 2'd0;
            idx_q      <= 4'd0;
            ok_idx_q   <= 2'd0;
            err_idx_q  <= 3'd0;
            ok_hit_q   <= 1'b0;
            err_hit_q  <= 1'b0;
            cnt_q      <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            to_q       <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            idx_q      <= idx_d;
            ok_idx_q   <= ok_idx_d;
            err_idx_q  <= err_idx_d;
            ok_hit_q   <= ok_hit_d;
            err_hit_q  <= err_hit_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            to_q       <= to_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rx_ready_q <= 1'b1;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign resp_ok_o      = ok_q;
    assign resp_err_o     = err_q;
    assign resp_timeout_o = to_q;
    assign tx_valid_o     = tx_valid_q;
    assign tx_data_o      = tx_data_q;
    assign rx_ready_o     = rx_ready_q;
endmodule

// File: tb/tb_esp_at_cmd.sv
// Bench for esp_at_cmd: a byte-queue / suffix-match model checked every cycle,
// plus directed scenarios with hand-computed byte sequences and latencies.
module tb_esp_at_cmd;
    localparam int T = 50;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst, cmd_start, tx_ready, rx_valid;
    logic [1:0] cmd_sel;
    logic [7:0] rx_data, tx_data;
    logic       busy, done, resp_ok, resp_err, resp_timeout, tx_valid, rx_ready;

    esp_at_cmd #(.TIMEOUT_CYCLES(32'd50)) dut (
        .clk_i(clk), .rst_i(rst), .cmd_sel_i(cmd_sel), .cmd_start_i(cmd_start),
        .busy_o(busy), .done_o(done), .resp_ok_o(resp_ok), .resp_err_o(resp_err),
        .resp_timeout_o(resp_timeout), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_ready_o(rx_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc = 0;
    int done_cnt = 0, done_cyc = 0;
    logic done_busy, done_ok;
    bq_t cmd_bytes[4];
    bq_t pat_ok, pat_err, cap;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        $display("FAIL %s: bound expired, got no event, required one (cycle %0d)", name, cyc);
    endtask

    function automatic bq_t with_crlf(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    function automatic bit ends_with(input bq_t h, input bq_t p);
        if (h.size() < p.size()) return 1'b0;
        for (int i = 0; i < p.size(); i++)
            if (h[h.size() - p.size() + i] != p[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Model: command as a byte queue, response as a history searched by suffix.
    int   m_phase, m_wait;
    logic m_busy, m_done, m_ok, m_err, m_to, m_tx_valid, m_rx_ready, m_pend_ok, m_pend_err;
    logic [7:0] m_tx_data;
    bq_t  m_txq, m_hist;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_busy = 0; m_done = 0; m_ok = 0; m_err = 0; m_to = 0;
            m_tx_valid = 0; m_tx_data = 8'h00; m_rx_ready = 0;
            m_txq.delete(); m_hist.delete();
        end else begin
            bit rxf, txf, got_ok, got_err;
            rxf = rx_valid && m_rx_ready;
            txf = m_tx_valid && tx_ready;
            m_rx_ready = 1; m_done = 0; got_ok = 0; got_err = 0;
            if (rxf && (m_phase == 1 || m_phase == 2)) begin
                m_hist.push_back(rx_data);
                got_ok  = ends_with(m_hist, pat_ok);
                got_err = ends_with(m_hist, pat_err);
            end
            case (m_phase)
                0: if (cmd_start) begin
                    m_txq = cmd_bytes[cmd_sel]; m_hist.delete();
                    m_pend_ok = 0; m_pend_err = 0; m_ok = 0; m_err = 0; m_to = 0;
                    m_busy = 1; m_phase = 1;
                end
                1: begin
                    if (got_ok) m_pend_ok = 1;
                    if (got_err) m_pend_err = 1;
                    if (txf) begin
                        void'(m_txq.pop_front());
                        if (m_txq.size() == 0) begin m_phase = 2; m_wait = 0; end
                    end
                end
                2: begin
                    m_wait++;
                    if (got_ok || m_pend_ok || got_err || m_pend_err || m_wait == T) begin
                        if (got_ok || m_pend_ok) m_ok = 1;
                        else if (got_err || m_pend_err) m_err = 1;
                        else m_to = 1;
                        m_phase = 3; m_busy = 0; m_done = 1;
                    end
                end
                default: m_phase = 0;
            endcase
            m_tx_valid = (m_phase == 1);
            if (m_txq.size() > 0) m_tx_data = m_txq[0];
        end
    end

    always @(negedge clk) begin
        chk("outputs", 32'({busy, done, resp_ok, resp_err, resp_timeout, tx_valid, tx_data, rx_ready}),
            32'({m_busy, m_done, m_ok, m_err, m_to, m_tx_valid, m_tx_data, m_rx_ready}));
        if (!rst && tx_valid && tx_ready) cap.push_back(tx_data);
        if (!rst && done) begin
            done_cnt++; done_cyc = cyc; done_busy = busy; done_ok = resp_ok;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [1:0] c);
        cmd_sel = c; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic send_rx(input bq_t q);
        foreach (q[i]) begin
            rx_valid = 1'b1; rx_data = q[i];
            tick();
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx_idle(output int m);
        m = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!tx_valid) begin m = cyc; return; end
        end
        bound_fail("tx_idle_wait");
    endtask

    task automatic wait_done(input int prev, output int d);
        d = 0;
        for (int i = 0; i < 200; i++) begin
            if (done_cnt > prev) begin d = done_cyc; return; end
            @(negedge clk);
        end
        bound_fail("done_wait");
    endtask

    task automatic chk_cap(input string name, input bq_t exp);
        chk({name, "_count"}, 32'(cap.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < cap.size(); i++)
            chk({name, "_byte"}, 32'(cap[i]), 32'(exp[i]));
    endtask

    initial begin
        int m, d, prev;
        bq_t exp;
        cmd_bytes[0] = with_crlf("AT");
        cmd_bytes[1] = with_crlf("ATE0");
        cmd_bytes[2] = with_crlf("AT+RST");
        cmd_bytes[3] = with_crlf("AT+CWMODE=1");
        pat_ok  = with_crlf("OK");
        pat_err = with_crlf("ERROR");
        rst = 0; cmd_start = 0; cmd_sel = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;
        #1 rst = 1;
        repeat (3) tick();
        rst = 0;
        chk("reset_rx_ready", 32'(rx_ready), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_tx_data", 32'(tx_data), 0);
        tick();
        chk("rx_ready_rise", 32'(rx_ready), 1);

        // Loopback: AT\r\n, response ten cycles later
        tx_ready = 1; cap.delete(); prev = done_cnt;
        start_cmd(2'd0);
        chk("start_busy", 32'(busy), 1);
        chk("start_first_byte", 32'(tx_data), 32'h41);
        wait_tx_idle(m);
        repeat (10) tick();
        send_rx(with_crlf(""));
        send_rx(pat_ok);
        wait_done(prev, d);
        exp = '{8'h41, 8'h54, 8'h0D, 8'h0A};
        chk_cap("loopback_tx", exp);
        chk("loopback_done_ok", 32'(done_ok), 1);
        chk("loopback_done_busy", 32'(done_busy), 0);

        // ERROR with stalling transmitter; response overlaps the send
        tx_ready = 0; cap.delete(); prev = done_cnt;
        start_cmd(2'd3);
        fork
            begin
                for (int i = 0; i < 40; i++) begin tx_ready = ~tx_ready; tick(); end
                tx_ready = 1;
            end
            begin
                repeat (2) tick();
                send_rx(cmd_bytes[3]);
                send_rx(with_crlf(""));
                send_rx(pat_err);
            end
        join
        wait_done(prev, d);
        exp = '{8'h41, 8'h54, 8'h2B, 8'h43, 8'h57, 8'h4D, 8'h4F, 8'h44, 8'h45, 8'h3D, 8'h31, 8'h0D, 8'h0A};
        chk_cap("cwmode_tx", exp);
        chk("error_resp_err", 32'(resp_err), 1);
        chk("error_resp_ok", 32'(resp_ok), 0);

        // Partial-match restart, then a response arriving while idle
        prev = done_cnt;
        start_cmd(2'd0);
        wait_tx_idle(m);
        send_rx(with_crlf("OOK"));
        wait_done(prev, d);
        chk("partial_ok", 32'(resp_ok), 1);
        prev = done_cnt;
        send_rx(with_crlf("EERROR"));
        repeat (3) tick();
        chk("idle_ok_held", 32'(resp_ok), 1);
        chk("idle_err_clear", 32'(resp_err), 0);
        chk("idle_no_done", 32'(done_cnt), 32'(prev));

        // Timeout: no response at all
        prev = done_cnt;
        start_cmd(2'd1);
        wait_tx_idle(m);
        wait_done(prev, d);
        chk("timeout_latency", 32'(d - m), 50);
        chk("timeout_flag", 32'(resp_timeout), 1);

        // Match completing on the last timeout cycle wins
        prev = done_cnt;
        start_cmd(2'd0);
        wait_tx_idle(m);
        while (cyc < m + 46) tick();
        send_rx(pat_ok);
        wait_done(prev, d);
        chk("edge_latency", 32'(d - m), 50);
        chk("edge_ok", 32'(resp_ok), 1);
        chk("edge_timeout", 32'(resp_timeout), 0);

        // Start while busy is ignored
        cap.delete(); prev = done_cnt;
        start_cmd(2'd2);
        repeat (2) tick();
        start_cmd(2'd0);
        wait_tx_idle(m);
        send_rx(pat_ok);
        wait_done(prev, d);
        exp = '{8'h41, 8'h54, 8'h2B, 8'h52, 8'h53, 8'h54, 8'h0D, 8'h0A};
        chk_cap("rst_cmd_tx", exp);

        // Reset in SEND, then a clean restart
        start_cmd(2'd1);
        repeat (2) tick();
        rst = 1;
        #1;
        chk("async_tx_valid", 32'(tx_valid), 0);
        chk("async_busy", 32'(busy), 0);
        repeat (2) tick();
        rst = 0;
        tick();
        cap.delete(); prev = done_cnt;
        start_cmd(2'd1);
        wait_tx_idle(m);
        send_rx(pat_ok);
        wait_done(prev, d);
        exp = '{8'h41, 8'h54, 8'h45, 8'h30, 8'h0D, 8'h0A};
        chk_cap("restart_tx", exp);
        chk("restart_ok", 32'(resp_ok), 1);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/esp_at_cmd.md
# esp_at_cmd

AT-command initiator for the PMOD ESP32 link. On request it streams one of four fixed AT command strings into the UART transmit byte channel, then scans the UART receive byte channel for the module's final result line (`OK\r\n` or `ERROR\r\n`) and reports the outcome or a timeout. It sits between the system control logic and UART_COM, replacing the echo loopback in `esp_ctrl`, and is the side that originates commands the ESP32 answers.

## Interface
- `TIMEOUT_CYCLES`, default 100_000_000, is the response timeout in `clk` cycles (1 s at 100 MHz). Legal range is 2 to 2^32-1.
- `clk`, input, 1 bit: system clock. The only clock.
- `rst`, input, 1 bit: reset. Asynchronous, active-high.
- `cmd_sel`, input, 2 bits: command index, sampled on `cmd_start`.
  - 0 = `AT\r\n`, length 4.
  - 1 = `ATE0\r\n`, length 6.
  - 2 = `AT+RST\r\n`, length 8.
  - 3 = `AT+CWMODE=1\r\n`, length 13.
- `cmd_start`, input, 1 bit: start pulse. Honoured only in IDLE.
- `busy`, output, 1 bit: high from the cycle after an accepted start until the result is reported.
- `done`, output, 1 bit: one-cycle pulse when a command completes.
- `resp_ok`, output, 1 bit: last command ended with `OK\r\n`. Held until the next accepted start.
- `resp_err`, output, 1 bit: last command ended with `ERROR\r\n`. Held.
- `resp_timeout`, output, 1 bit: last command timed out. Held.
- `tx_data`, output, 8 bits: byte to UART_COM transmitter.
- `tx_valid`, output, 1 bit: `tx_data` is valid.
- `tx_ready`, input, 1 bit: transmitter accepts the byte.
- `rx_data`, input, 8 bits: byte from UART_COM receiver.
- `rx_valid`, input, 1 bit: `rx_data` is valid.
- `rx_ready`, output, 1 bit: this block accepts the byte.

## Operation
- Transfers:
  - A TX transfer occurs when `tx_valid && tx_ready`.
  - An RX transfer occurs when `rx_valid && rx_ready`.
- FSM states are IDLE, SEND, WAIT_RESP and DONE.
- IDLE: on `cmd_start`, latch `cmd_sel`, clear all `resp_*` flags, clear the byte index and the matchers, then go to SEND.
- SEND:
  - `tx_valid`=1 and `tx_data` = ROM[cmd][idx].
  - On a TX transfer, idx increments.
  - A TX transfer of the last byte (idx = len-1) goes to WAIT_RESP and loads the timeout counter with 0.
- WAIT_RESP:
  - `tx_valid`=0 and the counter increments every cycle.
  - A completed `OK\r\n` match sets `resp_ok` and goes to DONE.
  - A completed `ERROR\r\n` match sets `resp_err` and goes to DONE.
  - Counter = `TIMEOUT_CYCLES`-1 with no match completing in that cycle sets `resp_timeout` and goes to DONE.
  - A match completing in the same cycle as the timeout wins: the match flag is set and the timeout flag is not.
- DONE: `done`=1 for exactly one cycle, `busy`=0, then go to IDLE.
- RX path:
  - `rx_ready` is 1 in every state after reset, so the channel always drains.
  - Bytes received in IDLE or DONE are discarded and do not affect the matchers.
  - Matchers are active in SEND and WAIT_RESP, so a fast response overlapping the echo is not lost. A completion during SEND is recorded and taken in the first WAIT_RESP cycle.
- Matchers:
  - Two independent index counters, 0..3 for OK and 0..6 for ERROR.
  - On an RX transfer, an index advances if the byte equals the expected character.
  - Otherwise the index resets to 1 if the byte equals the first character (`O`/`E`), else to 0.
  - Echoed command text and intermediate lines (e.g. `ready`) are ignored by the matchers.
- A `cmd_start` while `busy` or in DONE is ignored; no queueing.
- Reset mid-command abandons it:
  - Go to IDLE.
  - `tx_valid` drops immediately (asynchronous). A byte partially handed to UART_COM is not this block's concern.

## Timing
- Reset values:
  - `busy`=0, `done`=0.
  - `resp_ok`=`resp_err`=`resp_timeout`=0.
  - `tx_valid`=0, `tx_data`=8'h00.
  - `rx_ready`=0; it rises at the first `clk` edge after `rst` deasserts.
- All outputs are registered.
- Start to first byte: `cmd_start` sampled high at edge N gives `busy`=1 and `tx_valid`=1 with the first byte after edge N.
- `tx_data` is held stable while `tx_valid && !tx_ready`. With `tx_ready` tied high, one byte transfers per cycle.
- Last byte transferred at edge M: WAIT_RESP after edge M.
- Final match byte transferred at edge K: DONE after edge K, with `done`=1, `busy`=0 and the result flag valid. Flags are valid in the same cycle as `done`.
- Timeout: exactly `TIMEOUT_CYCLES` cycles in WAIT_RESP, then `done`.

## Test plan
- Loopback check:
  - Stimulus: `cmd_sel`=0 with `tx_ready`=1; send `\r\nOK\r\n` 10 cycles after the last TX byte.
  - Required: TX bytes 41 54 0D 0A in 4 consecutive cycles; then `done` pulse with `resp_ok`=1 and `busy` low in the same cycle.
- ERROR response:
  - Stimulus: `cmd_sel`=3 with `tx_ready` toggling 1/0; respond echo + `ERROR\r\n`.
  - Required: 13 bytes sent in order with data held during stalls; `resp_err`=1, `resp_ok`=0.
- Partial-match restart:
  - Stimulus: respond `OOK\r\n` then `EERROR\r\n`.
  - Required: `resp_ok` set after the first sequence; the second sequence is discarded in IDLE and the flags are unchanged.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=50 with no RX.
  - Required: `done` exactly 50 cycles after WAIT_RESP entry, `resp_timeout`=1. A match on the final cycle gives `resp_ok`=1 and `resp_timeout`=0.
- Start during busy, and reset in SEND:
  - Stimulus: second `cmd_start` mid-SEND; then `rst` pulse.
  - Required: the start is ignored and the byte sequence is unaltered; `rst` forces `tx_valid`=0 and `busy`=0 immediately; the next command sends from byte 0.
